// File: rtl/serial_word_feeder_pkg.sv
// Shared definitions for the serial word feeder: direction codes, FSM
// encoding and the counter width helper.
package serial_word_feeder_pkg;

  // Direction codes as seen by the downstream shift register.
  localparam logic DIR_LEFT  = 1'b0;  // bits enter at Q3
  localparam logic DIR_RIGHT = 1'b1;  // bits enter at Q0

  // Default word length: the 4-bit shift register being fed.
  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bit-index counter width, $clog2(w), kept at least 1 bit wide.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_word_feeder_bit_index_counter.sv
// Mod-WIDTH up counter tracking which bit of the word is on 'd'.
// Clear has priority over enable; tc flags the last bit (cnt == WIDTH-1).
module bit_index_counter
  import serial_word_feeder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int                CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt;

  // Count bits of the word in flight, wrapping after the last one.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/serial_word_feeder.sv
// Serial word feeder: accepts parallel words over valid/ready and shifts
// them one bit per clock into a bidirectional shift register, ordering the
// bits so the word lands in q[0:WIDTH-1] as given. word_done pulses in the
// cycle the downstream register holds the complete word.
module serial_word_feeder
  import serial_word_feeder_pkg::*;
#(
  parameter int   WIDTH    = WIDTH_DEFAULT,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:WIDTH-1] word_in,
  input  logic             dir_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             d,
  output logic             direccion,
  output logic             word_done,
  output logic             busy
);

  state_t           state;
  state_t           state_nxt;
  logic             tc;
  logic             accept;
  logic [WIDTH-1:0] ord_in;  // incoming word in send order, bit 0 first
  logic [WIDTH-1:0] rest;    // bits still to send, next one at bit 0

  bit_index_counter #(
    .WIDTH (WIDTH)
  ) u_bit_index_counter (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (busy),
    .tc  (tc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: enter SHIFT on accept, leave it after the last bit unless
  // the next word is taken back-to-back.
  // NOTE: defaulting every always_comb output first prevents latch inference.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = ST_SHIFT;
    end else if (state == ST_SHIFT && tc) begin
      state_nxt = ST_IDLE;
    end
  end

  // Handshake outputs: ready when idle or on the last bit; never in reset.
  always_comb begin
    busy     = (state == ST_SHIFT);
    in_ready = !rst && ((state == ST_IDLE) || ((state == ST_SHIFT) && tc));
    accept   = in_valid && in_ready;
  end

  // Reorder the incoming word so bit 0 is sent first in either direction:
  // right shifts fill from Q0, so the LSB-side bit must go out first.
  always_comb begin
    ord_in = '0;
    for (int k = 0; k < WIDTH; k++) begin
      ord_in[k] = (dir_in == DIR_RIGHT) ? word_in[WIDTH-1-k] : word_in[k];
    end
  end

  // Registered serial outputs; direction only moves at the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d         <= IDLE_BIT;
      direccion <= DIR_LEFT;
      word_done <= 1'b0;
      rest      <= '0;
    end else begin
      word_done <= busy && tc;
      if (accept) begin
        d         <= ord_in[0];
        rest      <= ord_in >> 1;
        direccion <= dir_in;
      end else if (busy && !tc) begin
        d    <= rest[0];
        rest <= rest >> 1;
      end else begin
        d <= IDLE_BIT;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder with a behavioural 4-bit bidirectional
// shift register attached (d -> d, direccion -> direccion).
module tb_serial_word_feeder;

  localparam int   WIDTH    = 4;
  localparam logic IDLE_BIT = 1'b0;

  logic             clk = 1'b0;
  logic             rst;
  logic [0:WIDTH-1] word_in;
  logic             dir_in;
  logic             in_valid;
  logic             in_ready;
  logic             d;
  logic             direccion;
  logic             word_done;
  logic             busy;

  logic [0:3]       q = '0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [0:3] word;
    logic       dir;
    logic [0:3] seq;  // expected d values, seq[0] first
  } vec_t;

  vec_t vecs[4];

  serial_word_feeder #(
    .WIDTH    (WIDTH),
    .IDLE_BIT (IDLE_BIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .word_in   (word_in),
    .dir_in    (dir_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .direccion (direccion),
    .word_done (word_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Downstream shift register: right enters Q0, left enters Q3; no enable.
  always @(posedge clk) begin
    if (direccion) q <= {d, q[0:2]};
    else           q <= {q[1:3], d};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic [0:3] seq;

    vecs[0] = '{word: 4'b1011, dir: 1'b1, seq: 4'b1101};
    vecs[1] = '{word: 4'b0110, dir: 1'b0, seq: 4'b0110};
    vecs[2] = '{word: 4'b1110, dir: 1'b1, seq: 4'b0111};
    vecs[3] = '{word: 4'b0100, dir: 1'b0, seq: 4'b0100};

    rst      = 1'b1;
    in_valid = 1'b0;
    word_in  = '0;
    dir_in   = 1'b0;

    // Reset state.
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_d", d, IDLE_BIT);
    check("rst_dir", direccion, 0);
    check("rst_busy", busy, 0);
    check("rst_done", word_done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle for 10 cycles: downstream drains to zero.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("idle_d_%0d", c), d, IDLE_BIT);
      check($sformatf("idle_done_%0d", c), word_done, 0);
      check($sformatf("idle_busy_%0d", c), busy, 0);
      check($sformatf("idle_ready_%0d", c), in_ready, 1);
    end
    check("idle_q", q, 4'b0000);

    // Single words from IDLE, table-driven.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("v%0d_ready_idle", i), in_ready, 1);
      check($sformatf("v%0d_done_idle", i), word_done, 0);
      word_in  = vecs[i].word;
      dir_in   = vecs[i].dir;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      word_in  = ~vecs[i].word;
      dir_in   = ~vecs[i].dir;
      for (int k = 0; k < 4; k++) begin
        if (k > 0) @(negedge clk);
        check($sformatf("v%0d_d%0d", i, k), d, vecs[i].seq[k]);
        check($sformatf("v%0d_dir%0d", i, k), direccion, vecs[i].dir);
        check($sformatf("v%0d_busy%0d", i, k), busy, 1);
        check($sformatf("v%0d_ready%0d", i, k), in_ready, (k == 3) ? 1 : 0);
        check($sformatf("v%0d_done%0d", i, k), word_done, 0);
      end
      @(negedge clk);
      check($sformatf("v%0d_done", i), word_done, 1);
      check($sformatf("v%0d_q", i), q, vecs[i].word);
      check($sformatf("v%0d_busy_end", i), busy, 0);
      check($sformatf("v%0d_d_end", i), d, IDLE_BIT);
    end
    @(negedge clk);
    check("v_done_once", word_done, 0);

    // Back-to-back with in_valid held: 1000/right then 0001/left.
    word_in  = 4'b1000;
    dir_in   = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    word_in = 4'b0001;
    dir_in  = 1'b0;
    seq = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("b2b_a_d%0d", k), d, seq[k]);
      check($sformatf("b2b_a_dir%0d", k), direccion, 1);
      check($sformatf("b2b_a_ready%0d", k), in_ready, (k == 3) ? 1 : 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_a_done", word_done, 1);
    check("b2b_a_q", q, 4'b1000);
    check("b2b_b_busy", busy, 1);
    check("b2b_b_dir_flip", direccion, 0);
    seq = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("b2b_b_d%0d", k), d, seq[k]);
      check($sformatf("b2b_b_dir%0d", k), direccion, 0);
      check($sformatf("b2b_b_ready%0d", k), in_ready, (k == 3) ? 1 : 0);
      if (k > 0) check($sformatf("b2b_b_done%0d", k), word_done, 0);
    end
    @(negedge clk);
    check("b2b_b_done", word_done, 1);
    check("b2b_b_q", q, 4'b0001);
    check("b2b_b_idle", busy, 0);

    // Stall: 0011/right in flight, 1111 offered at cnt=1, changed to 0101/left.
    @(negedge clk);
    word_in  = 4'b0011;
    dir_in   = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    word_in  = 4'b1111;
    dir_in   = 1'b1;
    in_valid = 1'b1;
    check("stall_ready_c1", in_ready, 0);
    @(negedge clk);
    check("stall_ready_c2", in_ready, 0);
    check("stall_d_c2", d, 0);
    word_in = 4'b0101;
    dir_in  = 1'b0;
    @(negedge clk);
    check("stall_ready_c3", in_ready, 1);
    check("stall_d_c3", d, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("stall_a_done", word_done, 1);
    check("stall_a_q", q, 4'b0011);
    seq = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("stall_b_d%0d", k), d, seq[k]);
      check($sformatf("stall_b_dir%0d", k), direccion, 0);
    end
    @(negedge clk);
    check("stall_b_done", word_done, 1);
    check("stall_b_q", q, 4'b0101);

    // Reset mid-word: 1100/right, async reset during cnt=2.
    @(negedge clk);
    word_in  = 4'b1100;
    dir_in   = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_before", busy, 1);
    check("mid_dir_before", direccion, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_d", d, IDLE_BIT);
    check("mid_rst_dir", direccion, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("mid_ready_after", in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("mid_no_done_%0d", c), word_done, 0);
      check($sformatf("mid_idle_busy_%0d", c), busy, 0);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
